sprite_rom_arbiter: RTL and testbench

Round-robin arbiter that lets up to NUM_REQ sprite renderers share one single-port palettized sprite ROM, such as a 50x50 digit ROM with 2-bit palette indices. It sits between the per-object draw logic and the ROM instance in the VGA pixel domain. It accepts one read per cycle, drives the ROM address, and routes each returned palette index back to its requester with a fixed latency. Palette lookup and RGB output remain in the requesters.

---
 rtl/sprite_rom_arbiter_if.sv | 24 ++
 rtl/sprite_rom_arbiter.sv | 68 ++++++
 tb/tb_sprite_rom_arbiter.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_rom_arbiter_if.sv
// sprite_rom_arbiter_if: request/grant, ROM port and response signals shared by
// the sprite renderers (master side) and the arbiter (slave side).
interface sprite_rom_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 12,
   parameter int DATA_W  = 2
);
   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ-1:0]        gnt;
   logic [ADDR_W-1:0]         rom_addr;
   logic                      rom_en;
   logic [DATA_W-1:0]         rom_q;
   logic [NUM_REQ-1:0]        rsp_valid;
   logic [DATA_W-1:0]         rsp_data;
   modport master (
      output req, req_addr, rom_q,
      input  gnt, rom_addr, rom_en, rsp_valid, rsp_data
   );
   modport slave (
      input  req, req_addr, rom_q,
      output gnt, rom_addr, rom_en, rsp_valid, rsp_data
   );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter: round-robin sharing of one single-port sprite ROM among NUM_REQ
// renderers, returning each palette index to its requester ROM_LAT+1 cycles after grant.
module sprite_rom_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 12,
   parameter int DATA_W  = 2,
   parameter int ROM_LAT = 1
) (
   input logic                 vga_clk,
   input logic                 reset_n,
   sprite_rom_arbiter_if.slave bus
);
   localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
   logic [PW-1:0]     ptr;
   logic [PW-1:0]     gid;
   logic [PW-1:0]     idx;
   logic [PW:0]       sum;
   logic              hit;
   logic [ADDR_W-1:0] sel_addr;
   logic              tv  [ROM_LAT];
   logic [PW-1:0]     tid [ROM_LAT];
   // Scan farthest to nearest so the closest requester after ptr is the last to win.
   always_comb begin
      hit = 1'b0;
      gid = '0;
      sum = '0;
      idx = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         sum = {1'b0, ptr} + (PW+1)'(k);
         idx = PW'(sum >= (PW+1)'(NUM_REQ) ? sum - (PW+1)'(NUM_REQ) : sum);
         if (bus.req[idx]) begin
            hit = 1'b1;
            gid = idx;
         end
      end
   end
   assign sel_addr = bus.req_addr[gid*ADDR_W +: ADDR_W];
   assign bus.gnt  = (reset_n && hit) ? NUM_REQ'(1) << gid : '0;
   always_ff @(posedge vga_clk) begin
      if (!reset_n) begin
         ptr           <= PW'(NUM_REQ - 1);
         bus.rom_addr  <= '0;
         bus.rom_en    <= 1'b0;
         bus.rsp_valid <= '0;
         bus.rsp_data  <= '0;
         for (int s = 0; s < ROM_LAT; s++) begin
            tv[s]  <= 1'b0;
            tid[s] <= '0;
         end
      end else begin
         bus.rom_en <= hit;
         if (hit) begin
            ptr          <= gid;
            bus.rom_addr <= sel_addr;
         end
         tv[0]  <= hit;
         tid[0] <= gid;
         for (int s = 1; s < ROM_LAT; s++) begin
            tv[s]  <= tv[s-1];
            tid[s] <= tid[s-1];
         end
         bus.rsp_valid <= tv[ROM_LAT-1] ? NUM_REQ'(1) << tid[ROM_LAT-1] : '0;
         if (tv[ROM_LAT-1]) bus.rsp_data <= DATA_W'(bus.rom_q);
      end
   end
   a_gnt_onehot: assert property (@(posedge vga_clk) $onehot0(bus.gnt));
   a_ptr_range:  assert property (@(posedge vga_clk) disable iff (!reset_n) int'(ptr) < NUM_REQ);
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb_sprite_rom_arbiter: randomized and directed checks of sprite_rom_arbiter against a
// queue-based round-robin/latency model, plus a 3-requester instance for wrap-around.
module tb_sprite_rom_arbiter;
   localparam int N  = 4;
   localparam int AW = 12;
   logic vga_clk = 1'b0;
   logic reset_n = 1'b0;
   int checks = 0;
   int failures = 0;
   always #5 vga_clk = ~vga_clk;
   sprite_rom_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(2)) bus ();
   sprite_rom_arbiter_if #(.NUM_REQ(3), .ADDR_W(AW), .DATA_W(2)) bus3 ();
   sprite_rom_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(2), .ROM_LAT(1)) dut (
      .vga_clk(vga_clk), .reset_n(reset_n), .bus(bus));
   sprite_rom_arbiter #(.NUM_REQ(3), .ADDR_W(AW), .DATA_W(2), .ROM_LAT(1)) dut3 (
      .vga_clk(vga_clk), .reset_n(reset_n), .bus(bus3));
   function automatic logic [1:0] rom_f(input logic [AW-1:0] x);
      return 2'(x ^ (x >> 3) ^ (x >> 7));
   endfunction
   // ROM clocked on the falling edge, so data is ready at the next rising edge.
   always @(negedge vga_clk) begin
      bus.rom_q  <= rom_f(bus.rom_addr);
      bus3.rom_q <= rom_f(bus3.rom_addr);
   end
   typedef struct {int id; logic [AW-1:0] addr; int due;} pend_t;
   pend_t pend[$];
   logic [N-1:0]  r;
   logic [AW-1:0] a [N];
   int last = N - 1;
   int cyc = 0;
   int gid;
   logic [N-1:0]  exp_gnt, exp_rv;
   logic [1:0]    exp_rd, rd_r;
   logic          en_r;
   logic [AW-1:0] addr_r;
   task automatic apply();
      bus.req = r;
      for (int i = 0; i < N; i++) bus.req_addr[i*AW +: AW] = a[i];
   endtask
   task automatic model_eval();
      exp_gnt = '0;
      gid = -1;
      if (reset_n)
         for (int k = 1; k <= N; k++)
            if (gid < 0 && r[(last + k) % N]) gid = (last + k) % N;
      if (gid >= 0) exp_gnt[gid] = 1'b1;
      exp_rv = '0;
      exp_rd = rd_r;
      if (pend.size() > 0 && pend[0].due == cyc) begin
         exp_rv[pend[0].id] = 1'b1;
         exp_rd = rom_f(pend[0].addr);
      end
   endtask
   task automatic model_commit();
      if (!reset_n) begin
         last = N - 1;
         pend.delete();
         en_r = 1'b0;
         addr_r = '0;
         rd_r = '0;
      end else begin
         rd_r = exp_rd;
         if (exp_rv != '0) void'(pend.pop_front());
         en_r = gid >= 0;
         if (gid >= 0) begin
            last = gid;
            addr_r = a[gid];
            pend.push_back('{id: gid, addr: a[gid], due: cyc + 2});
         end
      end
      cyc++;
   endtask
   task automatic test_reset();
      r = '0;
      for (int i = 0; i < N; i++) a[i] = '0;
      reset_n = 1'b0;
      repeat (2) begin
         apply(); @(negedge vga_clk); model_eval(); @(posedge vga_clk); model_commit(); #1;
      end
      r = '1;
      bus3.req = '1;
      apply(); @(negedge vga_clk); model_eval();
      checks += 6;
      if (bus.gnt !== '0) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", bus.gnt); end
      if (bus3.gnt !== '0) begin failures++; $display("FAIL reset_gnt3 got=%b exp=000", bus3.gnt); end
      if (bus.rom_en !== 1'b0) begin failures++; $display("FAIL reset_rom_en got=%b exp=0", bus.rom_en); end
      if (bus.rom_addr !== '0) begin failures++; $display("FAIL reset_rom_addr got=%h exp=000", bus.rom_addr); end
      if (bus.rsp_valid !== '0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0000", bus.rsp_valid); end
      if (bus.rsp_data !== '0) begin failures++; $display("FAIL reset_rsp_data got=%h exp=0", bus.rsp_data); end
      @(posedge vga_clk); model_commit(); #1;
      bus3.req = '0;
   endtask
   task automatic test_two_req();
      reset_n = 1'b1;
      r = 4'b0101;
      a[0] = 12'h010; a[1] = 12'h020; a[2] = 12'h030; a[3] = 12'h040;
      for (int k = 0; k < 6; k++) begin
         apply(); @(negedge vga_clk); model_eval();
         checks += 5;
         if (bus.gnt !== exp_gnt) begin failures++; $display("FAIL two_gnt k=%0d got=%b exp=%b", k, bus.gnt, exp_gnt); end
         if (bus.rom_en !== en_r) begin failures++; $display("FAIL two_rom_en k=%0d got=%b exp=%b", k, bus.rom_en, en_r); end
         if (bus.rom_addr !== addr_r) begin failures++; $display("FAIL two_rom_addr k=%0d got=%h exp=%h", k, bus.rom_addr, addr_r); end
         if (bus.rsp_valid !== exp_rv) begin failures++; $display("FAIL two_rsp_valid k=%0d got=%b exp=%b", k, bus.rsp_valid, exp_rv); end
         if (bus.rsp_data !== exp_rd) begin failures++; $display("FAIL two_rsp_data k=%0d got=%h exp=%h", k, bus.rsp_data, exp_rd); end
         if (k < 2) begin
            checks++;
            if (bus.gnt !== (k == 0 ? 4'b0001 : 4'b0100)) begin failures++; $display("FAIL two_gnt_fixed k=%0d got=%b", k, bus.gnt); end
         end
         if (k == 2) begin
            checks++;
            if (bus.rsp_valid !== 4'b0001 || bus.rsp_data !== rom_f(12'h010)) begin
               failures++; $display("FAIL two_first_rsp got=%b/%h exp=0001/%h", bus.rsp_valid, bus.rsp_data, rom_f(12'h010));
            end
         end
         @(posedge vga_clk); model_commit(); #1;
      end
   endtask
   task automatic test_all_req();
      int wait_c [N];
      for (int i = 0; i < N; i++) wait_c[i] = 0;
      r = '1;
      for (int k = 0; k < 12; k++) begin
         apply(); @(negedge vga_clk); model_eval();
         checks += 5;
         if (bus.gnt !== exp_gnt) begin failures++; $display("FAIL all_gnt k=%0d got=%b exp=%b", k, bus.gnt, exp_gnt); end
         if (bus.rom_en !== en_r) begin failures++; $display("FAIL all_rom_en k=%0d got=%b exp=%b", k, bus.rom_en, en_r); end
         if (bus.rom_addr !== addr_r) begin failures++; $display("FAIL all_rom_addr k=%0d got=%h exp=%h", k, bus.rom_addr, addr_r); end
         if (bus.rsp_valid !== exp_rv) begin failures++; $display("FAIL all_rsp_valid k=%0d got=%b exp=%b", k, bus.rsp_valid, exp_rv); end
         if (bus.rsp_data !== exp_rd) begin failures++; $display("FAIL all_rsp_data k=%0d got=%h exp=%h", k, bus.rsp_data, exp_rd); end
         for (int i = 0; i < N; i++) begin
            if (bus.gnt[i] === 1'b1) begin
               checks++;
               if (wait_c[i] >= N) begin failures++; $display("FAIL all_fairness req=%0d waited=%0d max=%0d", i, wait_c[i] + 1, N); end
               wait_c[i] = 0;
            end else wait_c[i]++;
         end
         @(posedge vga_clk); model_commit(); #1;
         if (gid >= 0) a[gid] = AW'($urandom);
      end
   endtask
   task automatic test_back_to_back();
      r = 4'b0100;
      for (int k = 0; k < 6; k++) begin
         if (k < 3) a[2] = AW'(k); else r = '0;
         apply(); @(negedge vga_clk); model_eval();
         checks += 5;
         if (bus.gnt !== exp_gnt) begin failures++; $display("FAIL b2b_gnt k=%0d got=%b exp=%b", k, bus.gnt, exp_gnt); end
         if (bus.rom_en !== en_r) begin failures++; $display("FAIL b2b_rom_en k=%0d got=%b exp=%b", k, bus.rom_en, en_r); end
         if (bus.rom_addr !== addr_r) begin failures++; $display("FAIL b2b_rom_addr k=%0d got=%h exp=%h", k, bus.rom_addr, addr_r); end
         if (bus.rsp_valid !== exp_rv) begin failures++; $display("FAIL b2b_rsp_valid k=%0d got=%b exp=%b", k, bus.rsp_valid, exp_rv); end
         if (bus.rsp_data !== exp_rd) begin failures++; $display("FAIL b2b_rsp_data k=%0d got=%h exp=%h", k, bus.rsp_data, exp_rd); end
         if (k < 3) begin
            checks++;
            if (bus.gnt !== 4'b0100) begin failures++; $display("FAIL b2b_gnt_fixed k=%0d got=%b exp=0100", k, bus.gnt); end
         end
         if (k >= 2 && k <= 4) begin
            checks++;
            if (bus.rsp_valid !== 4'b0100 || bus.rsp_data !== rom_f(AW'(k - 2))) begin
               failures++; $display("FAIL b2b_rsp_fixed k=%0d got=%b/%h exp=0100/%h", k, bus.rsp_valid, bus.rsp_data, rom_f(AW'(k - 2)));
            end
         end
         @(posedge vga_clk); model_commit(); #1;
      end
   endtask
   task automatic test_mid_reset();
      r = '1;
      for (int i = 0; i < N; i++) a[i] = AW'($urandom);
      for (int k = 0; k < 9; k++) begin
         reset_n = (k != 3);
         apply(); @(negedge vga_clk); model_eval();
         checks += 5;
         if (bus.gnt !== exp_gnt) begin failures++; $display("FAIL mrst_gnt k=%0d got=%b exp=%b", k, bus.gnt, exp_gnt); end
         if (bus.rom_en !== en_r) begin failures++; $display("FAIL mrst_rom_en k=%0d got=%b exp=%b", k, bus.rom_en, en_r); end
         if (bus.rom_addr !== addr_r) begin failures++; $display("FAIL mrst_rom_addr k=%0d got=%h exp=%h", k, bus.rom_addr, addr_r); end
         if (bus.rsp_valid !== exp_rv) begin failures++; $display("FAIL mrst_rsp_valid k=%0d got=%b exp=%b", k, bus.rsp_valid, exp_rv); end
         if (bus.rsp_data !== exp_rd) begin failures++; $display("FAIL mrst_rsp_data k=%0d got=%h exp=%h", k, bus.rsp_data, exp_rd); end
         if (k == 4) begin
            checks += 3;
            if (bus.rom_en !== 1'b0) begin failures++; $display("FAIL mrst_en_after got=%b exp=0", bus.rom_en); end
            if (bus.rsp_valid !== '0) begin failures++; $display("FAIL mrst_discard got=%b exp=0000", bus.rsp_valid); end
            if (bus.gnt !== 4'b0001) begin failures++; $display("FAIL mrst_first_gnt got=%b exp=0001", bus.gnt); end
         end
         if (k == 5) begin
            checks++;
            if (bus.rsp_valid !== '0) begin failures++; $display("FAIL mrst_discard2 got=%b exp=0000", bus.rsp_valid); end
         end
         @(posedge vga_clk); model_commit(); #1;
         if (gid >= 0) a[gid] = AW'($urandom);
      end
   endtask
   task automatic test_withdraw();
      for (int k = 0; k < 7; k++) begin
         reset_n = (k != 0);
         r = k == 1 ? 4'b0011 : (k >= 2 && k <= 4) ? 4'b0001 : 4'b0000;
         a[0] = AW'(12'h200 + k);
         a[1] = 12'h3ff;
         apply(); @(negedge vga_clk); model_eval();
         checks += 6;
         if (bus.gnt !== exp_gnt) begin failures++; $display("FAIL wd_gnt k=%0d got=%b exp=%b", k, bus.gnt, exp_gnt); end
         if (bus.rom_en !== en_r) begin failures++; $display("FAIL wd_rom_en k=%0d got=%b exp=%b", k, bus.rom_en, en_r); end
         if (bus.rom_addr !== addr_r) begin failures++; $display("FAIL wd_rom_addr k=%0d got=%h exp=%h", k, bus.rom_addr, addr_r); end
         if (bus.rsp_valid !== exp_rv) begin failures++; $display("FAIL wd_rsp_valid k=%0d got=%b exp=%b", k, bus.rsp_valid, exp_rv); end
         if (bus.rsp_data !== exp_rd) begin failures++; $display("FAIL wd_rsp_data k=%0d got=%h exp=%h", k, bus.rsp_data, exp_rd); end
         if (bus.gnt[1] !== 1'b0 || bus.rsp_valid[1] !== 1'b0) begin
            failures++; $display("FAIL wd_req1_served k=%0d gnt=%b rsp_valid=%b exp bit1=0", k, bus.gnt, bus.rsp_valid);
         end
         @(posedge vga_clk); model_commit(); #1;
      end
   endtask
   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         reset_n = $urandom_range(49) != 0;
         apply(); @(negedge vga_clk); model_eval();
         checks += 5;
         if (bus.gnt !== exp_gnt) begin failures++; $display("FAIL rnd_gnt k=%0d got=%b exp=%b", k, bus.gnt, exp_gnt); end
         if (bus.rom_en !== en_r) begin failures++; $display("FAIL rnd_rom_en k=%0d got=%b exp=%b", k, bus.rom_en, en_r); end
         if (bus.rom_addr !== addr_r) begin failures++; $display("FAIL rnd_rom_addr k=%0d got=%h exp=%h", k, bus.rom_addr, addr_r); end
         if (bus.rsp_valid !== exp_rv) begin failures++; $display("FAIL rnd_rsp_valid k=%0d got=%b exp=%b", k, bus.rsp_valid, exp_rv); end
         if (bus.rsp_data !== exp_rd) begin failures++; $display("FAIL rnd_rsp_data k=%0d got=%h exp=%h", k, bus.rsp_data, exp_rd); end
         @(posedge vga_clk); model_commit(); #1;
         for (int i = 0; i < N; i++) begin
            if (r[i] && gid == i) begin
               r[i] = $urandom_range(1);
               a[i] = AW'($urandom);
            end else if (r[i]) r[i] = $urandom_range(7) != 0;
            else if ($urandom_range(9) < 4) begin
               r[i] = 1'b1;
               a[i] = AW'($urandom);
            end
         end
      end
      reset_n = 1'b1;
   endtask
   task automatic test_nonpow2();
      bus3.req = 3'b111;
      for (int i = 0; i < 3; i++) bus3.req_addr[i*AW +: AW] = AW'(12'h100 + i);
      for (int k = 0; k < 8; k++) begin
         logic [2:0] eg, ev;
         eg = 3'b001 << (k % 3);
         ev = k >= 2 ? 3'b001 << ((k - 2) % 3) : 3'b000;
         @(negedge vga_clk);
         checks += 2;
         if (bus3.gnt !== eg) begin failures++; $display("FAIL np2_gnt k=%0d got=%b exp=%b", k, bus3.gnt, eg); end
         if (bus3.rsp_valid !== ev) begin failures++; $display("FAIL np2_rsp_valid k=%0d got=%b exp=%b", k, bus3.rsp_valid, ev); end
         if (k >= 2) begin
            checks++;
            if (bus3.rsp_data !== rom_f(AW'(12'h100 + (k - 2) % 3))) begin
               failures++; $display("FAIL np2_rsp_data k=%0d got=%h exp=%h", k, bus3.rsp_data, rom_f(AW'(12'h100 + (k - 2) % 3)));
            end
         end
         @(posedge vga_clk); #1;
      end
      bus3.req = '0;
   endtask
   initial begin
      #1_000_000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end
   initial begin
      bus.req = '0;
      bus.req_addr = '0;
      bus3.req = '0;
      bus3.req_addr = '0;
      @(posedge vga_clk); #1;
      test_reset();
      test_two_req();
      test_all_req();
      test_back_to_back();
      test_mid_reset();
      test_withdraw();
      test_random();
      test_nonpow2();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
